// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 1-bit-shift combinational ALU: decodes RV32I ALU ops and sequences multi-bit shifts.
// Optional statistics counters (busy_cycles, retired) are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_ctrl #(
   parameter int SUPPRESS_X0 = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_func,
   input  logic [31:0] alu_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] rd_val,
   output logic [4:0]  rd_addr,
   output logic        illegal
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [31:0] busy_cycles,
   output logic [31:0] retired
`endif
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [3:0] F_ADD  = 4'b0000;
   localparam logic [3:0] F_SUB  = 4'b0001;
   localparam logic [3:0] F_SLL  = 4'b0100;
   localparam logic [3:0] F_SRL  = 4'b0101;
   localparam logic [3:0] F_AND  = 4'b1000;
   localparam logic [3:0] F_OR   = 4'b1001;
   localparam logic [3:0] F_XOR  = 4'b1010;
   localparam logic [3:0] F_NONE = 4'b1111;

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

   state_t      state;
   logic [4:0]  count;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        dec_legal;
   logic        dec_shift;
   logic [3:0]  dec_func;
   logic [31:0] dec_b;
   logic [4:0]  dec_shamt;
   logic        unused_rs1_field;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // The register-file indices of the sources are resolved upstream.
   assign unused_rs1_field = ^instr[19:15];

   always_comb begin
      dec_legal = 1'b0;
      dec_shift = 1'b0;
      dec_func  = F_ADD;
      dec_b     = rs2_val;
      dec_shamt = rs2_val[4:0];
      case (opcode)
         OP_R: begin
            if (funct7 == 7'b0000000) begin
               dec_legal = 1'b1;
               case (funct3)
                  3'b000: dec_func = F_ADD;
                  3'b100: dec_func = F_XOR;
                  3'b110: dec_func = F_OR;
                  3'b111: dec_func = F_AND;
                  3'b001: begin dec_func = F_SLL; dec_shift = 1'b1; end
                  3'b101: begin dec_func = F_SRL; dec_shift = 1'b1; end
                  default: dec_legal = 1'b0;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec_legal = 1'b1;
               dec_func  = F_SUB;
            end
         end
         OP_I: begin
            dec_b     = {{20{instr[31]}}, instr[31:20]};
            dec_shamt = instr[24:20];
            case (funct3)
               3'b000: begin dec_legal = 1'b1; dec_func = F_ADD; end
               3'b100: begin dec_legal = 1'b1; dec_func = F_XOR; end
               3'b110: begin dec_legal = 1'b1; dec_func = F_OR;  end
               3'b111: begin dec_legal = 1'b1; dec_func = F_AND; end
               3'b001: begin
                  dec_legal = (funct7 == 7'b0000000);
                  dec_func  = F_SLL;
                  dec_shift = 1'b1;
               end
               3'b101: begin
                  dec_legal = (funct7 == 7'b0000000);
                  dec_func  = F_SRL;
                  dec_shift = 1'b1;
               end
               default: dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   function automatic logic [31:0] wb_val(input logic [31:0] v, input logic [4:0] rd);
      wb_val = (SUPPRESS_X0 != 0 && rd == 5'd0) ? 32'h0 : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         rd_val    <= 32'h0;
         rd_addr   <= 5'd0;
         illegal   <= 1'b0;
         alu_a     <= 32'h0;
         alu_b     <= 32'h0;
         alu_func  <= F_NONE;
         count     <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  rd_addr  <= instr[11:7];
                  if (!dec_legal) begin
                     illegal   <= 1'b1;
                     rd_val    <= 32'h0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     illegal <= 1'b0;
                     alu_a   <= rs1_val;
                     if (dec_shift && dec_shamt != 5'd0) begin
                        alu_b    <= 32'h0;
                        alu_func <= dec_func;
                        count    <= dec_shamt;
                        state    <= SHIFT;
                     end else if (dec_shift) begin
                        // Zero-distance shift degenerates to a pass-through add.
                        alu_b    <= 32'h0;
                        alu_func <= F_ADD;
                        state    <= EXEC;
                     end else begin
                        alu_b    <= dec_b;
                        alu_func <= dec_func;
                        state    <= EXEC;
                     end
                  end
               end
            end
            EXEC: begin
               rd_val    <= wb_val(alu_out, rd_addr);
               out_valid <= 1'b1;
               alu_a     <= 32'h0;
               alu_b     <= 32'h0;
               alu_func  <= F_NONE;
               state     <= DONE;
            end
            SHIFT: begin
               count <= count - 5'd1;
               if (count == 5'd1) begin
                  rd_val    <= wb_val(alu_out, rd_addr);
                  out_valid <= 1'b1;
                  alu_a     <= 32'h0;
                  alu_b     <= 32'h0;
                  alu_func  <= F_NONE;
                  state     <= DONE;
               end else begin
                  alu_a <= alu_out;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cycles <= 32'h0;
         retired     <= 32'h0;
      end else begin
         if (state != IDLE) busy_cycles <= busy_cycles + 32'h1;
         if (out_valid && out_ready) retired <= retired + 32'h1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl against a transaction-level model, plus directed literal cases.
module tb_alu_issue_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = 32'h0;
   logic [31:0] rs1_val = 32'h0;
   logic [31:0] rs2_val = 32'h0;
   logic [31:0] alu_a, alu_b, alu_out, rd_val;
   logic [3:0]  alu_func;
   logic        out_valid, illegal;
   logic        out_ready = 1'b0;
   logic [4:0]  rd_addr;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] busy_cycles, retired;
`endif

   int checks = 0;
   int passes = 0;
   bit hold = 1'b0;

   alu_issue_ctrl #(.SUPPRESS_X0(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
      .out_valid(out_valid), .out_ready(out_ready), .rd_val(rd_val),
      .rd_addr(rd_addr), .illegal(illegal)
`ifdef ALU_ISSUE_STATS_EN
      , .busy_cycles(busy_cycles), .retired(retired)
`endif
   );

   always #5 clk = ~clk;

   // Reference ALU: one-bit shifts only.
   always_comb begin
      case (alu_func)
         4'b0000: alu_out = alu_a + alu_b;
         4'b0001: alu_out = alu_a - alu_b;
         4'b1010: alu_out = alu_a ^ alu_b;
         4'b1001: alu_out = alu_a | alu_b;
         4'b1000: alu_out = alu_a & alu_b;
         4'b0100: alu_out = alu_a << 1;
         4'b0101: alu_out = alu_a >> 1;
         default: alu_out = 32'h0;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
   endtask

   // Transaction model: ph 0=idle 1=busy 2=result pending
   int          ph = 0;
   int          m_rem, m_lat, m_n;
   logic [31:0] m_rd, m_a0, m_b;
   logic [4:0]  m_addr;
   logic        m_ill, m_shl, m_sh;
   logic [3:0]  m_func;
   logic [31:0] m_busy = 0, m_ret = 0;

   task automatic predict(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] imm, res;
      logic        legal;
      legal = 1'b0; res = 0; m_sh = 0; m_shl = 0; m_n = 0; m_func = 4'h0;
      imm = {{20{i[31]}}, i[31:20]};
      m_b = (i[6:0] == 7'h13) ? imm : b;
      if (i[6:0] == 7'h33 && i[31:25] == 7'h20 && i[14:12] == 3'd0) begin
         legal = 1; res = a - b; m_func = 4'h1;
      end else if (i[6:0] == 7'h33 || i[6:0] == 7'h13) begin
         case (i[14:12])
            3'd0: begin res = a + m_b; m_func = 4'h0; legal = 1; end
            3'd4: begin res = a ^ m_b; m_func = 4'hA; legal = 1; end
            3'd6: begin res = a | m_b; m_func = 4'h9; legal = 1; end
            3'd7: begin res = a & m_b; m_func = 4'h8; legal = 1; end
            3'd1, 3'd5: begin
               legal = 1; m_sh = 1; m_shl = (i[14:12] == 3'd1);
               m_n = (i[6:0] == 7'h33) ? int'(b[4:0]) : int'(i[24:20]);
               res = m_shl ? a << m_n : a >> m_n;
            end
            default: legal = 0;
         endcase
         if (i[6:0] == 7'h33 && i[31:25] != 7'h0) legal = 0;
         if (i[6:0] == 7'h13 && m_sh && i[31:25] != 7'h0) legal = 0;
      end
      if (m_sh) begin
         m_b = 0;
         m_func = (m_n == 0) ? 4'h0 : (m_shl ? 4'h4 : 4'h5);
      end
      m_a0   = a;
      m_addr = i[11:7];
      m_ill  = !legal;
      m_lat  = !legal ? 0 : ((m_sh && m_n > 0) ? m_n : 1);
      m_rd   = (!legal || m_addr == 0) ? 32'h0 : res;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = 0; m_busy = 0; m_ret = 0;
      end else begin
         if (ph != 0) m_busy = m_busy + 1;
         case (ph)
            0: if (in_valid) begin
                  predict(instr, rs1_val, rs2_val);
                  m_rem = m_lat;
                  ph = (m_lat == 0) ? 2 : 1;
               end
            1: begin m_rem--; if (m_rem == 0) ph = 2; end
            default: if (out_ready) begin ph = 0; m_ret = m_ret + 1; end
         endcase
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", 32'(in_ready), 32'(ph == 0));
         chk("out_valid", 32'(out_valid), 32'(ph == 2));
         if (ph == 2) begin
            chk("rd_val", rd_val, m_rd);
            chk("rd_addr", 32'(rd_addr), 32'(m_addr));
            chk("illegal", 32'(illegal), 32'(m_ill));
         end
         if (ph == 1) begin
            chk("alu_func", 32'(alu_func), 32'(m_func));
            chk("alu_b", alu_b, m_b);
            if (m_sh && m_n > 0)
               chk("alu_a_shift", alu_a, m_shl ? m_a0 << (m_n - m_rem) : m_a0 >> (m_n - m_rem));
            else
               chk("alu_a", alu_a, m_a0);
         end else begin
            chk("alu_func_idle", 32'(alu_func), 32'hF);
            chk("alu_ab_idle", alu_a | alu_b, 32'h0);
         end
`ifdef ALU_ISSUE_STATS_EN
         chk("busy_cycles", busy_cycles, m_busy);
         chk("retired", retired, m_ret);
`endif
      end
   end

   initial forever begin
      @(negedge clk);
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin @(negedge clk); w++; end
      chk("issue_wait", 32'(in_ready), 32'h1);
      instr = i; rs1_val = a; rs2_val = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
   endtask

   task automatic expect_res(input string nm, input logic [31:0] e_rd, input logic [4:0] e_addr,
                             input logic e_ill, input int e_lat);
      int lat = 0, busy = 0;
      while (!out_valid && lat < 100) begin
         if (alu_func != 4'hF) busy++;
         @(negedge clk);
         lat++;
      end
      chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
      chk({nm, "_alu_cycles"}, 32'(busy), 32'(e_ill ? 0 : e_lat));
      chk({nm, "_rd_val"}, rd_val, e_rd);
      chk({nm, "_rd_addr"}, 32'(rd_addr), 32'(e_addr));
      chk({nm, "_illegal"}, 32'(illegal), 32'(e_ill));
   endtask

   function automatic logic [31:0] rnd_instr();
      int         k  = $urandom_range(0, 9);
      logic [4:0] rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      logic [2:0] f3 = 3'($urandom);
      logic [6:0] f7;
      if (k <= 4) begin
         f7 = (k == 4) ? ((($urandom & 1) != 0) ? 7'h20 : 7'($urandom)) : 7'h0;
         return {f7, 5'($urandom), 5'($urandom), f3, rd, 7'h33};
      end else if (k <= 6) begin
         return {12'($urandom), 5'($urandom), f3, rd, 7'h13};
      end else if (k <= 8) begin
         f7 = (k == 8) ? 7'($urandom) : 7'h0;
         return {f7, 5'($urandom), 5'($urandom), f3, rd, 7'h13};
      end
      return $urandom;
   endfunction

   initial begin
      logic [31:0] held;
      int          seen;
      #12;
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_rd_val", rd_val, 32'h0);
      chk("reset_rd_addr", 32'(rd_addr), 32'h0);
      chk("reset_illegal", 32'(illegal), 32'h0);
      chk("reset_alu_func", 32'(alu_func), 32'hF);
      @(negedge clk); rst_n = 1'b1;

      issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'hFFFF_FFFF, 32'h1);
      expect_res("add", 32'h0, 5'd3, 1'b0, 1);
      issue({7'h20, 5'd2, 5'd1, 3'b000, 5'd5, 7'h33}, 32'd5, 32'd7);
      expect_res("sub", 32'hFFFF_FFFE, 5'd5, 1'b0, 1);
      issue({12'hFFF, 5'd1, 3'b000, 5'd4, 7'h13}, 32'd10, 32'h0);
      expect_res("addi", 32'd9, 5'd4, 1'b0, 1);
      issue({7'h00, 5'd4, 5'd1, 3'b001, 5'd6, 7'h13}, 32'h8000_0001, 32'h0);
      expect_res("slli4", 32'h0000_0010, 5'd6, 1'b0, 4);
      issue({7'h00, 5'd2, 5'd1, 3'b101, 5'd7, 7'h33}, 32'h8000_0000, 32'd33);
      expect_res("srl1", 32'h4000_0000, 5'd7, 1'b0, 1);
      issue({7'h00, 5'd2, 5'd1, 3'b101, 5'd7, 7'h33}, 32'h1234_5678, 32'd0);
      expect_res("srl0", 32'h1234_5678, 5'd7, 1'b0, 1);
      issue({7'h00, 5'd31, 5'd1, 3'b001, 5'd9, 7'h13}, 32'h0000_0003, 32'h0);
      expect_res("slli31", 32'h8000_0000, 5'd9, 1'b0, 31);
      issue({7'h20, 5'd2, 5'd1, 3'b101, 5'd8, 7'h33}, 32'hDEAD_BEEF, 32'd3);
      expect_res("sra_illegal", 32'h0, 5'd8, 1'b1, 0);
      issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33}, 32'd5, 32'd6);
      expect_res("add_x0", 32'h0, 5'd0, 1'b0, 1);

      // Backpressure: result must hold while writeback stalls.
      hold = 1'b1;
      issue({7'h00, 5'd2, 5'd1, 3'b110, 5'd10, 7'h33}, 32'hF0F0_0000, 32'h0000_0F0F);
      expect_res("or_bp", 32'hF0F0_0F0F, 5'd10, 1'b0, 1);
      held = rd_val;
      repeat (5) begin
         @(negedge clk);
         chk("bp_rd_val", rd_val, held);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
      end
      hold = 1'b0;

      // Reset in the middle of a long shift.
      issue({7'h00, 5'd20, 5'd1, 3'b001, 5'd11, 7'h13}, 32'h1, 32'h0);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'h1);
      chk("rst_mid_alu_func", 32'(alu_func), 32'hF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin @(negedge clk); if (out_valid) seen++; end
      chk("rst_no_result", 32'(seen), 32'h0);

      for (int n = 0; n < 250; n++) begin
         issue(rnd_instr(), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, passed=%0d of %0d", passes, checks);
      $fatal(1);
   end
endmodule
